bcd_day_counter: RTL
====================

BCD_DAY_COUNTER -- requirements
Module: bcd_day_counter

Interface
REQ-001 Parameter DIGITS, default 3: number of BCD digits held; legal range 2..4.
REQ-002 Parameter MIN_VAL, default 1: lowest count value (first day).
REQ-003 Parameter MAX_VAL, default 365: highest count value when leap=0.
REQ-004 Legal parameter sets SHALL satisfy 0 <= MIN_VAL < MAX_VAL and MAX_VAL+1 <= 10^DIGITS-1.
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 tick  input  1  one-cycle count enable from the clock divider, synchronous to clk.
REQ-008 run_key_n  input  1  raw active-low pushbutton, asynchronous to clk; each press toggles run/pause.
REQ-009 clr  input  1  synchronous clear to MIN_VAL, active-high.
REQ-010 leap  input  1  1 extends the top value to MAX_VAL+1.
REQ-011 down  input  1  count direction, 1 = decrement; used only under COUNTER_DOWN_EN.
REQ-012 bcd  output  4*DIGITS  count value, digit i in bits [4i+3:4i], digit 0 least significant.
REQ-013 running  output  1  1 in state RUN.
REQ-014 wrap  output  1  one-cycle pulse on the cycle the count wraps.

Function
REQ-015 Two-state FSM, PAUSE and RUN; a press detection toggles PAUSE<->RUN.
REQ-016 run_key_n SHALL pass through a two-flop synchroniser (flops reset to 1), and a press is a 1->0 transition on the second stage.
REQ-017 running SHALL change on the rising edge after the press is detected: 3 clk edges after the first edge that samples run_key_n low.
REQ-018 TOP = MAX_VAL+leap, evaluated combinationally each cycle.
REQ-019 The count SHALL update only on an edge where tick=1 and state=RUN; otherwise bcd holds.
REQ-020 Up step: if value >= TOP, next = MIN_VAL and wrap=1; else next = value+1 with per-digit BCD carry (9->0, carry into next digit).
REQ-021 Each bcd digit SHALL always be in the range 0..9; binary values 10..15 are never produced.
REQ-022 bcd and wrap SHALL have one-cycle latency from the sampled tick; wrap is high in the same cycle as the wrapped value.
REQ-023 clr=1 SHALL load MIN_VAL on the next edge regardless of state or tick, with wrap=0; clr has priority over counting.
REQ-024 A press coincident with tick SHALL NOT affect that tick: the tick is applied using the pre-toggle state.
REQ-025 leap falling while value = MAX_VAL+1 SHALL cause the next up step to wrap to MIN_VAL (REQ-020 uses >=).
REQ-026 wrap SHALL be 0 in all cycles other than those in REQ-020 and REQ-030.

Reset
REQ-027 reset low SHALL immediately force bcd=MIN_VAL in BCD, state=PAUSE, running=0, wrap=0, and synchroniser flops=1.
REQ-028 Reset assertion mid-count SHALL discard the count, and no wrap pulse SHALL be generated.
REQ-029 After reset release, the first count SHALL occur on the first tick in RUN.

Configuration
REQ-030 With COUNTER_DOWN_EN defined and down=1, a step SHALL give next = TOP if value <= MIN_VAL or value > TOP (wrap=1 only when value <= MIN_VAL), else value-1 with BCD borrow (0->9).
REQ-031 Without COUNTER_DOWN_EN, down SHALL be ignored, the block SHALL count up only, and no decrement logic is built.

Verification
REQ-032 Reset, press once, 5 ticks -> bcd=0x006, running=1, wrap never high.
REQ-033 leap=0, preload to 364 via ticks, 2 ticks -> 365 then 001 with wrap=1 for exactly one cycle; repeat with leap=1 -> 365, 366, then 001 with wrap.
REQ-034 Count to 099, tick -> 100 (double carry); 109 -> 110; no digit ever exceeds 9.
REQ-035 Second press -> running=0; 10 ticks -> bcd unchanged; clr pulse with tick -> 001 and wrap=0.
REQ-036 With COUNTER_DOWN_EN, down=1 at 001, tick -> 365 with wrap=1; at 100, tick -> 099.
REQ-037 reset asserted between clk edges at value 200 -> bcd=001 and running=0 before the next edge; run_key_n glitch shorter than one clk period low -> at most one toggle.

Source files
------------

// File: rtl/bcd_day_counter_if.sv
// Control and status bundle for bcd_day_counter.
// The slave modport is the counter; the master modport is whoever drives it.
interface bcd_day_counter_if #(
  parameter int DIGITS = 3
);
  logic                  tick;
  logic                  run_key_n;
  logic                  clr;
  logic                  leap;
  logic                  down;
  logic [4*DIGITS-1:0]   bcd;
  logic                  running;
  logic                  wrap;

  modport slave (
    input  tick, run_key_n, clr, leap, down,
    output bcd, running, wrap
  );

  modport master (
    output tick, run_key_n, clr, leap, down,
    input  bcd, running, wrap
  );
endinterface

// File: rtl/bcd_day_counter.sv
// BCD day counter with run/pause pushbutton toggle.
// Counts MIN_VAL..MAX_VAL (MAX_VAL+1 when leap=1) in BCD on tick while running.
// Optional macro COUNTER_DOWN_EN adds decrement when down=1.
//
//  state | meaning
//  PAUSE | count held, ticks ignored
//  RUN   | count steps on each tick
module bcd_day_counter #(
  parameter int DIGITS  = 3,
  parameter int MIN_VAL = 1,
  parameter int MAX_VAL = 365
) (
  input  logic               clk,
  input  logic               reset,
  bcd_day_counter_if.slave   s
);
  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Digit-valid BCD words order the same as the values they encode,
  // so all range compares are done directly on BCD.
  localparam logic [W-1:0] MIN_BCD   = to_bcd(MIN_VAL);
  localparam logic [W-1:0] MAX_BCD   = to_bcd(MAX_VAL);
  localparam logic [W-1:0] MAXP1_BCD = to_bcd(MAX_VAL + 1);

  typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q;
  logic          running_q;
  logic          sync1_q, sync2_q, sync2_dly_q;
  logic          press_q, press_d;
  logic [W-1:0]  bcd_q, bcd_d;
  logic          wrap_q, wrap_d;
  logic [W-1:0]  top_bcd;
  logic [W-1:0]  inc_bcd;
  logic          inc_carry;

  // Press detection: 1->0 edge on the synchronised key, registered.
  always_comb begin
    press_d = sync2_dly_q & ~sync2_q;
  end

  // Key synchroniser, edge-history flop and registered press flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sync2_dly_q <= 1'b1;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= s.run_key_n;
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
      press_q     <= press_d;
    end
  end

  // Run/pause FSM; running is registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= PAUSE;
      running_q <= 1'b0;
    end else if (press_q) begin
      case (state_q)
        PAUSE: begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        default: begin
          state_q   <= PAUSE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // BCD increment with per-digit carry.
  always_comb begin
    inc_bcd   = bcd_q;
    inc_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (bcd_q[4*i +: 4] >= 4'd9) begin
          inc_bcd[4*i +: 4] = 4'd0;
        end else begin
          inc_bcd[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
    end
  end

`ifdef COUNTER_DOWN_EN
  logic [W-1:0] dec_bcd;
  logic         dec_borrow;

  // BCD decrement with per-digit borrow.
  always_comb begin
    dec_bcd    = bcd_q;
    dec_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (dec_borrow) begin
        if (bcd_q[4*i +: 4] == 4'd0) begin
          dec_bcd[4*i +: 4] = 4'd9;
        end else begin
          dec_bcd[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
    end
  end
`else
  logic unused_down;
  assign unused_down = s.down;
`endif

  // Next count and wrap; clear wins, counting uses the pre-toggle state.
  always_comb begin
    top_bcd = s.leap ? MAXP1_BCD : MAX_BCD;
    bcd_d   = bcd_q;
    wrap_d  = 1'b0;
    if (s.clr) begin
      bcd_d = MIN_BCD;
    end else if (s.tick && (state_q == RUN)) begin
`ifdef COUNTER_DOWN_EN
      if (s.down) begin
        if ((bcd_q <= MIN_BCD) || (bcd_q > top_bcd)) begin
          bcd_d  = top_bcd;
          wrap_d = (bcd_q <= MIN_BCD);
        end else begin
          bcd_d = dec_bcd;
        end
      end else
`endif
      begin
        if (bcd_q >= top_bcd) begin
          bcd_d  = MIN_BCD;
          wrap_d = 1'b1;
        end else begin
          bcd_d = inc_bcd;
        end
      end
    end
  end

  // Count and wrap registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_q  <= MIN_BCD;
      wrap_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
    end
  end

  assign s.bcd     = bcd_q;
  assign s.running = running_q;
  assign s.wrap    = wrap_q;
endmodule
